// File: rtl/pure_sine_gen.sv
// DDS sine generator: 16-bit phase accumulator feeding a quarter-wave sine table,
// with registered 8-bit sample plus first-order sigma-delta and PWM 1-bit DAC streams.
module pure_sine_gen (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic [15:0] acc_q, acc_d;
  logic [7:0]  sample_q, sample_d;
  logic [7:0]  sd_q, sd_d;
  logic        sdo_q, sdo_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        pwmo_q, pwmo_d;

  logic [7:0]  phase;
  logic [6:0]  qidx;
  logic [6:0]  qmag;
  logic [7:0]  sine_val;
  logic [8:0]  sd_sum;
  logic        unused_uio;

  // round(127*sin(pi*k/128)) for k = 0..64; the other three quadrants are mirrored from it
  function automatic logic [6:0] quarter_sine(input logic [6:0] k);
    case (k)
      7'd0:  return 7'd0;   7'd1:  return 7'd3;   7'd2:  return 7'd6;   7'd3:  return 7'd9;
      7'd4:  return 7'd12;  7'd5:  return 7'd16;  7'd6:  return 7'd19;  7'd7:  return 7'd22;
      7'd8:  return 7'd25;  7'd9:  return 7'd28;  7'd10: return 7'd31;  7'd11: return 7'd34;
      7'd12: return 7'd37;  7'd13: return 7'd40;  7'd14: return 7'd43;  7'd15: return 7'd46;
      7'd16: return 7'd49;  7'd17: return 7'd51;  7'd18: return 7'd54;  7'd19: return 7'd57;
      7'd20: return 7'd60;  7'd21: return 7'd63;  7'd22: return 7'd65;  7'd23: return 7'd68;
      7'd24: return 7'd71;  7'd25: return 7'd73;  7'd26: return 7'd76;  7'd27: return 7'd78;
      7'd28: return 7'd81;  7'd29: return 7'd83;  7'd30: return 7'd85;  7'd31: return 7'd88;
      7'd32: return 7'd90;  7'd33: return 7'd92;  7'd34: return 7'd94;  7'd35: return 7'd96;
      7'd36: return 7'd98;  7'd37: return 7'd100; 7'd38: return 7'd102; 7'd39: return 7'd104;
      7'd40: return 7'd106; 7'd41: return 7'd107; 7'd42: return 7'd109; 7'd43: return 7'd111;
      7'd44: return 7'd112; 7'd45: return 7'd113; 7'd46: return 7'd115; 7'd47: return 7'd116;
      7'd48: return 7'd117; 7'd49: return 7'd118; 7'd50: return 7'd120; 7'd51: return 7'd121;
      7'd52: return 7'd122; 7'd53: return 7'd122; 7'd54: return 7'd123; 7'd55: return 7'd124;
      7'd56: return 7'd125; 7'd57: return 7'd125; 7'd58: return 7'd126; 7'd59: return 7'd126;
      7'd60: return 7'd126; 7'd61: return 7'd127; 7'd62: return 7'd127; 7'd63: return 7'd127;
      7'd64: return 7'd127;
      default: return 7'd0;
    endcase
  endfunction

  always_comb begin
    phase    = acc_q[15:8];
    // second and fourth quadrants read the table backwards; p=64 maps to the peak entry
    qidx     = phase[6] ? (7'd64 - {1'b0, phase[5:0]}) : {1'b0, phase[5:0]};
    qmag     = quarter_sine(qidx);
    sine_val = phase[7] ? (8'd128 - {1'b0, qmag}) : (8'd128 + {1'b0, qmag});
    sd_sum   = {1'b0, sd_q} + {1'b0, sample_q};

    acc_d    = acc_q;
    sample_d = sample_q;
    sd_d     = sd_q;
    sdo_d    = sdo_q;
    cnt_d    = cnt_q;
    pwmo_d   = pwmo_q;
    if (ena) begin
      acc_d    = acc_q + {8'h00, ui_in};
      sample_d = sine_val;
      sd_d     = sd_sum[7:0];
      sdo_d    = sd_sum[8];
      cnt_d    = cnt_q + 8'd1;
      pwmo_d   = (cnt_q < sample_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= 16'h0000;
      sample_q <= 8'h80;
      sd_q     <= 8'h00;
      sdo_q    <= 1'b0;
      cnt_q    <= 8'h00;
      pwmo_q   <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      sample_q <= sample_d;
      sd_q     <= sd_d;
      sdo_q    <= sdo_d;
      cnt_q    <= cnt_d;
      pwmo_q   <= pwmo_d;
    end
  end

  assign uo_out     = sample_q;
  assign uio_out    = {6'b000000, pwmo_q, sdo_q};
  assign uio_oe     = 8'h03;
  assign unused_uio = ^uio_in;

endmodule

// File: tb/tb_pure_sine_gen.sv
// Self-checking bench for pure_sine_gen: randomized and directed stimulus against a
// cycle-level reference model built from the sine formula and the DAC counting rules.
module tb_pure_sine_gen;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  int m_acc, m_sample, m_sd, m_sdo, m_cnt, m_pwmo;

  pure_sine_gen dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int sine_ref(input int p);
    real x;
    x = 127.0 * $sin(2.0 * 3.14159265358979323846 * p / 256.0);
    if (x >= 0.0) return 128 + $rtoi($floor(x + 0.5));
    else          return 128 - $rtoi($floor(-x + 0.5));
  endfunction

  function automatic logic [23:0] model_pins();
    return {8'(m_sample), 6'b000000, 1'(m_pwmo), 1'(m_sdo), 8'h03};
  endfunction

  task automatic model_reset();
    m_acc = 0; m_sample = 128; m_sd = 0; m_sdo = 0; m_cnt = 0; m_pwmo = 0;
  endtask

  // one clock: the model consumes the inputs the DUT sees on this edge
  task automatic cycle();
    int total;
    @(posedge clk);
    if (rst_n && ena) begin
      total    = m_sd + m_sample;
      m_sdo    = (total >= 256) ? 1 : 0;
      m_sd     = total % 256;
      m_pwmo   = (m_cnt < m_sample) ? 1 : 0;
      m_cnt    = (m_cnt + 1) % 256;
      m_sample = sine_ref(m_acc / 256);
      m_acc    = (m_acc + int'(ui_in)) % 65536;
    end
    #1;
    uio_in = 8'($urandom);
  endtask

  task automatic apply_reset(input logic [7:0] ftw);
    rst_n = 1'b0;
    ena   = 1'b1;
    ui_in = ftw;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [23:0] got;
    rst_n = 1'b0;
    ena   = 1'b1;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      ui_in = 8'($urandom);
      @(posedge clk);
      #1;
      got = {uo_out, uio_out, uio_oe};
      n_checks++;
      if (got !== 24'h80_00_03) begin
        n_fail++;
        $display("FAIL reset_hold cycle %0d: got %h expected 800003", i, got);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_quarter_points();
    int exp_s, lo, hi;
    lo = 255; hi = 0;
    apply_reset(8'h40);
    for (int n = 1; n <= 1024; n++) begin
      cycle();
      exp_s = sine_ref(((n - 1) * 64 % 65536) / 256);
      if (int'(uo_out) < lo) lo = int'(uo_out);
      if (int'(uo_out) > hi) hi = int'(uo_out);
      n_checks++;
      if (int'(uo_out) !== exp_s) begin
        n_fail++;
        $display("FAIL quarter_sample n=%0d: uo_out %0d expected %0d", n, uo_out, exp_s);
      end
      n_checks++;
      if ({uo_out, uio_out, uio_oe} !== model_pins()) begin
        n_fail++;
        $display("FAIL quarter_pins n=%0d: got %h expected %h", n, {uo_out, uio_out, uio_oe}, model_pins());
      end
    end
    n_checks++;
    if (hi !== 255 || lo !== 1) begin
      n_fail++;
      $display("FAIL quarter_extremes: max %0d min %0d expected 255 and 1", hi, lo);
    end
  endtask

  task automatic test_dc_window(input int p_target, input int exp_s);
    int sd_ones, pwm_ones;
    apply_reset(8'h40);
    repeat (p_target * 4) cycle();
    ui_in = 8'h00;
    repeat (2) cycle();
    for (int w = 0; w < 2; w++) begin
      sd_ones = 0; pwm_ones = 0;
      for (int i = 0; i < 256; i++) begin
        cycle();
        sd_ones  += int'(uio_out[0]);
        pwm_ones += int'(uio_out[1]);
        n_checks++;
        if (int'(uo_out) !== exp_s) begin
          n_fail++;
          $display("FAIL dc_sample p=%0d: uo_out %0d expected %0d", p_target, uo_out, exp_s);
        end
      end
      n_checks++;
      if (sd_ones !== exp_s) begin
        n_fail++;
        $display("FAIL dc_sigma_delta p=%0d win %0d: ones %0d expected %0d", p_target, w, sd_ones, exp_s);
      end
      n_checks++;
      if (pwm_ones !== exp_s) begin
        n_fail++;
        $display("FAIL dc_pwm p=%0d win %0d: high %0d expected %0d", p_target, w, pwm_ones, exp_s);
      end
    end
  endtask

  task automatic test_dc_mid();
    int sd_ones, pwm_ones;
    apply_reset(8'h00);
    for (int w = 0; w < 2; w++) begin
      sd_ones = 0; pwm_ones = 0;
      for (int i = 0; i < 256; i++) begin
        cycle();
        sd_ones  += int'(uio_out[0]);
        pwm_ones += int'(uio_out[1]);
      end
      n_checks++;
      if (sd_ones !== 128 || pwm_ones !== 128) begin
        n_fail++;
        $display("FAIL dc128 win %0d: sd ones %0d pwm high %0d expected 128 each", w, sd_ones, pwm_ones);
      end
    end
  endtask

  task automatic test_ena_freeze();
    apply_reset(8'h10);
    repeat (100) begin
      cycle();
      n_checks++;
      if ({uo_out, uio_out, uio_oe} !== model_pins()) begin
        n_fail++;
        $display("FAIL freeze_pre: got %h expected %h", {uo_out, uio_out, uio_oe}, model_pins());
      end
    end
    ena = 1'b0;
    for (int i = 0; i < 50; i++) begin
      ui_in = 8'($urandom);
      cycle();
      n_checks++;
      if ({uo_out, uio_out, uio_oe} !== model_pins()) begin
        n_fail++;
        $display("FAIL freeze_hold %0d: got %h expected %h", i, {uo_out, uio_out, uio_oe}, model_pins());
      end
    end
    ena   = 1'b1;
    ui_in = 8'h10;
    repeat (100) begin
      cycle();
      n_checks++;
      if ({uo_out, uio_out, uio_oe} !== model_pins()) begin
        n_fail++;
        $display("FAIL freeze_resume: got %h expected %h", {uo_out, uio_out, uio_oe}, model_pins());
      end
    end
  endtask

  task automatic test_wrap();
    int exp_s;
    apply_reset(8'hFF);
    for (int n = 1; n <= 600; n++) begin
      cycle();
      exp_s = sine_ref(((n - 1) * 255 % 65536) / 256);
      n_checks++;
      if (int'(uo_out) !== exp_s || {uo_out, uio_out, uio_oe} !== model_pins()) begin
        n_fail++;
        $display("FAIL wrap n=%0d: got %h expected sample %0d pins %h", n, {uo_out, uio_out, uio_oe}, exp_s, model_pins());
      end
    end
  endtask

  task automatic test_random();
    apply_reset(8'($urandom));
    for (int i = 0; i < 600; i++) begin
      ena   = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) ui_in = 8'($urandom);
      if (i == 300) begin
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if ({uo_out, uio_out, uio_oe} !== 24'h80_00_03) begin
          n_fail++;
          $display("FAIL async_reset: got %h expected 800003", {uo_out, uio_out, uio_oe});
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
      end
      cycle();
      n_checks++;
      if ({uo_out, uio_out, uio_oe} !== model_pins()) begin
        n_fail++;
        $display("FAIL random %0d: got %h expected %h", i, {uo_out, uio_out, uio_oe}, model_pins());
      end
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    ena    = 1'b0;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    model_reset();
    test_reset();
    test_quarter_points();
    test_dc_mid();
    test_dc_window(64, 255);
    test_dc_window(192, 1);
    test_ena_freeze();
    test_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
